nec_ir_transmitter: RTL and testbench

- NEC-protocol infrared transmitter; the send side of the board's IRDA link.
- Takes an 8-bit address and 8-bit command and serialises a full NEC frame: leader, addr, ~addr, cmd, ~cmd (LSB first), stop mark.
- Also issues NEC repeat frames.
- Drives the IRDA_TXD LED pin, so frames are decodable by the team's NEC receiver.

---
 rtl/nec_ir_transmitter_if.sv | 20 ++
 rtl/nec_ir_transmitter.sv | 189 ++++++++++++++++++
 tb/tb_nec_ir_transmitter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/nec_ir_transmitter_if.sv
// Request/status bundle between a frame source and the NEC IR transmitter.
interface nec_ir_transmitter_if;
    logic       tx_start;
    logic       tx_repeat;
    logic [7:0] tx_addr;
    logic [7:0] tx_cmd;
    logic       tx_busy;
    logic       tx_done;
    logic       IRDA_TXD;

    modport master (
        output tx_start, tx_repeat, tx_addr, tx_cmd,
        input  tx_busy, tx_done, IRDA_TXD
    );

    modport slave (
        input  tx_start, tx_repeat, tx_addr, tx_cmd,
        output tx_busy, tx_done, IRDA_TXD
    );
endinterface

// File: rtl/nec_ir_transmitter.sv
// NEC infrared frame transmitter: full frames (leader, addr, ~addr, cmd, ~cmd, stop) and repeat frames.
// Optional 38 kHz carrier modulation of the mark envelope when IR_CARRIER_EN is defined.
//
// state      | meaning
// IDLE       | waiting for tx_start / tx_repeat
// LEAD_MARK  | 16T leader mark
// LEAD_SPACE | 8T leader space (full frame)
// REP_SPACE  | 4T leader space (repeat frame)
// BIT_MARK   | 1T mark preceding every data bit
// BIT_SPACE  | 1T (bit 0) or 3T (bit 1) space
// STOP_MARK  | 1T closing mark
module nec_ir_transmitter #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    nec_ir_transmitter_if.slave ir
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LEAD_MARK  = 3'd1;
    localparam logic [2:0] LEAD_SPACE = 3'd2;
    localparam logic [2:0] REP_SPACE  = 3'd3;
    localparam logic [2:0] BIT_MARK   = 3'd4;
    localparam logic [2:0] BIT_SPACE  = 3'd5;
    localparam logic [2:0] STOP_MARK  = 3'd6;

    localparam int DW = $clog2(16 * UNIT_CYCLES);

    localparam logic [DW-1:0] LIM_16T = DW'(16 * UNIT_CYCLES - 1);
    localparam logic [DW-1:0] LIM_8T  = DW'(8 * UNIT_CYCLES - 1);
    localparam logic [DW-1:0] LIM_4T  = DW'(4 * UNIT_CYCLES - 1);
    localparam logic [DW-1:0] LIM_3T  = DW'(3 * UNIT_CYCLES - 1);
    localparam logic [DW-1:0] LIM_1T  = DW'(UNIT_CYCLES - 1);

    if (UNIT_CYCLES < 1 || CARRIER_HALF < 1) begin : g_bad_param
        $error("nec_ir_transmitter: UNIT_CYCLES and CARRIER_HALF must be at least 1");
    end

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [31:0]   shift_q, shift_d;
    logic [5:0]    bits_q, bits_d;
    logic          rep_q, rep_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          txd_q, txd_d;
    logic [DW-1:0] limit;
    logic          dur_end;
    logic          mark_d;

    always_comb begin
        limit = LIM_1T;
        case (state_q)
            LEAD_MARK:  limit = LIM_16T;
            LEAD_SPACE: limit = LIM_8T;
            REP_SPACE:  limit = LIM_4T;
            BIT_SPACE:  limit = shift_q[0] ? LIM_3T : LIM_1T;
            default:    limit = LIM_1T;
        endcase
    end

    assign dur_end = (dur_q == limit);

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q + DW'(1);
        shift_d = shift_q;
        bits_d  = bits_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                dur_d = '0;
                // tx_start wins over tx_repeat; a repeat leaves the data registers untouched
                if (ir.tx_start) begin
                    shift_d = {~ir.tx_cmd, ir.tx_cmd, ~ir.tx_addr, ir.tx_addr};
                    bits_d  = 6'd0;
                    rep_d   = 1'b0;
                    state_d = LEAD_MARK;
                end else if (ir.tx_repeat) begin
                    rep_d   = 1'b1;
                    state_d = LEAD_MARK;
                end
            end
            LEAD_MARK: begin
                if (dur_end) state_d = rep_q ? REP_SPACE : LEAD_SPACE;
            end
            LEAD_SPACE: begin
                if (dur_end) state_d = BIT_MARK;
            end
            REP_SPACE: begin
                if (dur_end) state_d = STOP_MARK;
            end
            BIT_MARK: begin
                if (dur_end) state_d = BIT_SPACE;
            end
            BIT_SPACE: begin
                if (dur_end) begin
                    shift_d = {1'b0, shift_q[31:1]};
                    bits_d  = bits_q + 6'd1;
                    state_d = (bits_q == 6'd31) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK: begin
                if (dur_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                dur_d   = '0;
            end
        endcase
        if (state_d != state_q) dur_d = '0;
    end

    assign mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);
    assign busy_d = (state_d != IDLE);

`ifdef IR_CARRIER_EN
    localparam int CW = $clog2(CARRIER_HALF + 1);
    localparam logic [CW-1:0] CAR_LIM = CW'(CARRIER_HALF - 1);

    logic [CW-1:0] car_cnt_q, car_cnt_d;
    logic          car_ph_q, car_ph_d;

    // every mark is entered from a non-mark state, so a state change into mark restarts on a high half
    always_comb begin
        car_cnt_d = '0;
        car_ph_d  = 1'b0;
        if (mark_d && (state_d != state_q)) begin
            car_cnt_d = '0;
            car_ph_d  = 1'b1;
        end else if (mark_d) begin
            if (car_cnt_q == CAR_LIM) begin
                car_cnt_d = '0;
                car_ph_d  = ~car_ph_q;
            end else begin
                car_cnt_d = car_cnt_q + CW'(1);
                car_ph_d  = car_ph_q;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            car_cnt_q <= '0;
            car_ph_q  <= 1'b0;
        end else begin
            car_cnt_q <= car_cnt_d;
            car_ph_q  <= car_ph_d;
        end
    end

    assign txd_d = mark_d & car_ph_d;
`else
    assign txd_d = mark_d;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            dur_q   <= '0;
            shift_q <= '0;
            bits_q  <= '0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            txd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            txd_q   <= txd_d;
        end
    end

    assign ir.tx_busy  = busy_q;
    assign ir.tx_done  = done_q;
    assign ir.IRDA_TXD = txd_q;

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Directed bench for nec_ir_transmitter with a 4-cycle NEC unit.
module tb_nec_ir_transmitter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    nec_ir_transmitter_if ir ();

    nec_ir_transmitter #(.UNIT_CYCLES(4), .CARRIER_HALF(2)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .ir       (ir)
    );

    int n_vec = 0;
    int n_err = 0;
    bit exp_q[$];
    bit cap_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // expected envelope, one entry per clock, from the first busy cycle to the last stop-mark cycle
    task automatic build(input bit rep, input logic [7:0] a, input logic [7:0] c);
        logic [31:0] w;
        w = {~c, c, ~a, a};
        exp_q.delete();
        repeat (64) exp_q.push_back(1'b1);
        if (rep) begin
            repeat (16) exp_q.push_back(1'b0);
        end else begin
            repeat (32) exp_q.push_back(1'b0);
            for (int b = 0; b < 32; b++) begin
                repeat (4) exp_q.push_back(1'b1);
                repeat (w[b] ? 12 : 4) exp_q.push_back(1'b0);
            end
        end
        repeat (4) exp_q.push_back(1'b1);
    endtask

    task automatic request(input bit s, input bit r, input logic [7:0] a, input logic [7:0] c);
        @(negedge clk);
        ir.tx_start  = s;
        ir.tx_repeat = r;
        ir.tx_addr   = a;
        ir.tx_cmd    = c;
    endtask

    task automatic capture(input string tag, input bit release_req, input int poke_at);
        int wave_bad;
        int busy_cycles;
        int done_at;
        bit fin;
        wave_bad    = 0;
        busy_cycles = 0;
        done_at     = -1;
        fin         = 1'b0;
        cap_q.delete();
        for (int i = 0; i < exp_q.size() + 8 && !fin; i++) begin
            @(negedge clk);
            if (i == 0 && release_req) begin
                ir.tx_start  = 1'b0;
                ir.tx_repeat = 1'b0;
            end
            if (i == poke_at) begin
                ir.tx_repeat = 1'b1;
                ir.tx_addr   = 8'h66;
                ir.tx_cmd    = 8'h99;
            end
            if (i == poke_at + 1) ir.tx_repeat = 1'b0;
            cap_q.push_back(ir.IRDA_TXD);
            if (ir.tx_busy) busy_cycles++;
            if (i < exp_q.size() && ir.IRDA_TXD !== exp_q[i]) wave_bad++;
            if (ir.tx_done) begin
                done_at = i;
                fin     = 1'b1;
            end
        end
        check({tag, " wave"}, 32'(wave_bad), 32'd0);
        check({tag, " busy_len"}, 32'(busy_cycles), 32'(exp_q.size()));
        check({tag, " done_at"}, 32'(done_at), 32'(exp_q.size()));
    endtask

    function automatic logic [31:0] decode();
        int idx;
        int z;
        logic [31:0] v;
        idx = 96;
        v   = '0;
        for (int b = 0; b < 32; b++) begin
            idx += 4;
            z = 0;
            while (idx < cap_q.size() && cap_q[idx] == 1'b0) begin
                z++;
                idx++;
            end
            v[b] = (z > 8);
        end
        return v;
    endfunction

    initial begin
        int bad;
        int dones;
        ir.tx_start  = 1'b0;
        ir.tx_repeat = 1'b0;
        ir.tx_addr   = 8'h00;
        ir.tx_cmd    = 8'h00;

        // reset and idle
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst txd", 32'(ir.IRDA_TXD), 32'd0);
        check("rst busy", 32'(ir.tx_busy), 32'd0);
        check("rst done", 32'(ir.tx_done), 32'd0);
        rst_n = 1'b1;
        bad   = 0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (ir.IRDA_TXD !== 1'b0 || ir.tx_busy !== 1'b0) bad++;
            if (ir.tx_done !== 1'b0) dones++;
        end
        check("idle levels", 32'(bad), 32'd0);
        check("idle done", 32'(dones), 32'd0);

        // all-zero address and command
        request(1'b1, 1'b0, 8'h00, 8'h00);
        build(1'b0, 8'h00, 8'h00);
        capture("f00", 1'b1, -1);
        @(negedge clk);
        check("f00 done width", 32'(ir.tx_done), 32'd0);

        // mixed data, decoded from the captured waveform
        request(1'b1, 1'b0, 8'h5A, 8'hC3);
        build(1'b0, 8'h5A, 8'hC3);
        capture("f5a", 1'b1, -1);
        check("f5a bits", decode(), 32'h3CC3A55A);

        // repeat frame with junk data on the bus
        request(1'b0, 1'b1, 8'hFF, 8'hFF);
        build(1'b1, 8'hFF, 8'hFF);
        capture("rep", 1'b1, -1);

        // start and repeat together: full frame wins
        request(1'b1, 1'b1, 8'h12, 8'h34);
        build(1'b0, 8'h12, 8'h34);
        capture("both", 1'b1, -1);

        // start held through the frame, mid-frame repeat and data change, back-to-back second frame
        request(1'b1, 1'b0, 8'hA1, 8'h0F);
        build(1'b0, 8'hA1, 8'h0F);
        capture("held", 1'b0, 100);
        build(1'b0, 8'h66, 8'h99);
        capture("b2b", 1'b1, -1);

        // reset asserted mid-frame
        request(1'b1, 1'b0, 8'h33, 8'h55);
        @(negedge clk);
        ir.tx_start = 1'b0;
        repeat (199) @(negedge clk);
        check("mid busy", 32'(ir.tx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort txd", 32'(ir.IRDA_TXD), 32'd0);
        check("abort busy", 32'(ir.tx_busy), 32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (ir.tx_done !== 1'b0) dones++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (ir.tx_done !== 1'b0) dones++;
        end
        check("abort done", 32'(dones), 32'd0);
        request(1'b1, 1'b0, 8'h33, 8'h55);
        build(1'b0, 8'h33, 8'h55);
        capture("post", 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
